ranger_filter: RTL and testbench

Post-processing stage directly downstream of the ultrasonic ranger (`usensor`), upstream of the BCD/hex display path. It watches the ranger's echo line and captures each completed distance measurement on the echo falling edge. It clamps the measurement to 8 bits, keeps a 4-sample moving average, and drives a hysteretic proximity alarm. A stale flag reports when the sensor stops producing measurements.

---
 rtl/ranger_filter.sv | 155 +++++++++++++++
 tb/tb_ranger_filter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/ranger_filter.sv
// Ranger post-processing: captures each echo-fall measurement, clamps it to WIDTH bits,
// keeps a 4-sample moving average, drives a hysteretic proximity alarm and a stale flag.
module ranger_filter #(
    parameter int WIDTH   = 8,
    parameter int NEAR_TH = 20,
    parameter int FAR_TH  = 25,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             echo,
    input  logic [20:0]      distance_in,
    output logic [WIDTH-1:0] avg_out,
    output logic             avg_valid,
    output logic             near,
    output logic             stale
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALE = 2'd2;

    localparam logic [26:0]      TMR_LAST = 27'(TIMEOUT - 1);
    localparam logic [26:0]      TMR_MAX  = '1;
    localparam logic [WIDTH-1:0] NEAR_V   = WIDTH'(NEAR_TH);
    localparam logic [WIDTH-1:0] FAR_V    = WIDTH'(FAR_TH);

    logic             s1_q, s2_q, s3_q;
    logic [1:0]       state_q, state_d;
    logic [26:0]      timer_q, timer_d;
    logic [WIDTH-1:0] w0_q, w1_q, w2_q, w3_q;
    logic [WIDTH-1:0] w0_d, w1_d, w2_d, w3_d;
    logic             upd_q, upd_d;
    logic [WIDTH-1:0] avg_q, avg_d;
    logic             valid_q, valid_d;
    logic             near_q, near_d;

    logic             smp_evt;
    logic [WIDTH-1:0] sample;
    logic [WIDTH+1:0] sum;
    logic [WIDTH-1:0] mean;
    logic             prime, shift;

    always_comb begin
        smp_evt = !s2_q && s3_q;
        sample  = (distance_in[20:WIDTH] != '0) ? '1 : distance_in[WIDTH-1:0];
        sum     = {2'b00, w0_q} + {2'b00, w1_q} + {2'b00, w2_q} + {2'b00, w3_q};
        mean    = WIDTH'(sum >> 2);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        prime   = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (smp_evt) begin
                    prime   = 1'b1;
                    timer_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A sample on the timeout edge wins and keeps the block in RUN.
                if (smp_evt) begin
                    shift   = 1'b1;
                    timer_d = '0;
                end else begin
                    if (timer_q != TMR_MAX) timer_d = timer_q + 27'd1;
                    if (timer_q == TMR_LAST) state_d = ST_STALE;
                end
            end
            ST_STALE: begin
                if (smp_evt) begin
                    prime   = 1'b1;
                    timer_d = '0;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        w0_d = w0_q;
        w1_d = w1_q;
        w2_d = w2_q;
        w3_d = w3_q;
        if (prime) begin
            w0_d = sample;
            w1_d = sample;
            w2_d = sample;
            w3_d = sample;
        end else if (shift) begin
            w0_d = sample;
            w1_d = w0_q;
            w2_d = w1_q;
            w3_d = w2_q;
        end
        upd_d = prime || shift;
    end

    always_comb begin
        avg_d   = avg_q;
        valid_d = upd_q;
        near_d  = near_q;
        if (upd_q) avg_d = mean;
        // Alarm only moves on a fresh average; entering STALE forces it off.
        if (state_d == ST_STALE) begin
            near_d = 1'b0;
        end else if (upd_q) begin
            if (mean <= NEAR_V)     near_d = 1'b1;
            else if (mean >= FAR_V) near_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= ST_EMPTY;
            timer_q <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            upd_q   <= 1'b0;
            avg_q   <= '0;
            valid_q <= 1'b0;
            near_q  <= 1'b0;
        end else begin
            s1_q    <= echo;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            timer_q <= timer_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
            w3_q    <= w3_d;
            upd_q   <= upd_d;
            avg_q   <= avg_d;
            valid_q <= valid_d;
            near_q  <= near_d;
        end
    end

    assign avg_out   = avg_q;
    assign avg_valid = valid_q;
    assign near      = near_q;
    assign stale     = (state_q == ST_STALE);

endmodule

// File: tb/tb_ranger_filter.sv
// Directed bench for ranger_filter: priming, averaging, hysteresis, clamp, stale timing, reset.
module tb_ranger_filter;

    logic        clock;
    logic        resetn;
    logic        echo;
    logic [20:0] distance_in;
    logic [7:0]  avg_out;
    logic        avg_valid;
    logic        near;
    logic        stale;

    int unsigned errors = 0;
    int unsigned checks = 0;

    ranger_filter #(
        .WIDTH  (8),
        .NEAR_TH(20),
        .FAR_TH (25),
        .TIMEOUT(100)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .echo       (echo),
        .distance_in(distance_in),
        .avg_out    (avg_out),
        .avg_valid  (avg_valid),
        .near       (near),
        .stale      (stale)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the cycle in which avg_valid dropped.
    task automatic send(input string tag, input logic [20:0] d, input logic [7:0] exp_avg,
                        input logic exp_near);
        distance_in = d;
        echo        = 1'b1;
        repeat (2) @(negedge clock);
        echo = 1'b0;
        repeat (3) @(negedge clock);
        chk({tag, "_valid_early"}, avg_valid, 0);
        chk({tag, "_stale"}, stale, 0);
        @(negedge clock);
        chk({tag, "_valid"}, avg_valid, 1);
        chk({tag, "_avg"}, avg_out, exp_avg);
        chk({tag, "_near"}, near, exp_near);
        @(negedge clock);
        chk({tag, "_valid_pulse"}, avg_valid, 0);
    endtask

    initial begin
        resetn      = 1'b0;
        echo        = 1'b0;
        distance_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_avg", avg_out, 0);
        chk("rst_valid", avg_valid, 0);
        chk("rst_near", near, 0);
        chk("rst_stale", stale, 0);
        resetn = 1'b1;

        // EMPTY never times out.
        repeat (150) @(negedge clock);
        chk("empty_no_stale", stale, 0);
        chk("empty_no_valid", avg_valid, 0);

        send("prime40", 21'd40, 8'd40, 1'b0);
        send("avg32", 21'd10, 8'd32, 1'b0);
        send("avg25", 21'd10, 8'd25, 1'b0);
        send("avg17", 21'd10, 8'd17, 1'b1);
        send("avg10", 21'd10, 8'd10, 1'b1);
        send("hyst22", 21'd58, 8'd22, 1'b1);
        send("hyst25", 21'd22, 8'd25, 1'b0);
        send("hyst22b", 21'd0, 8'd22, 1'b0);
        send("hyst21", 21'd4, 8'd21, 1'b0);

        do_reset();
        send("clamp300", 21'd300, 8'd255, 1'b0);
        send("clampmax", 21'h1FFFFF, 8'd255, 1'b0);

        do_reset();
        send("stale_prime", 21'd10, 8'd10, 1'b1);
        // Time the next fall so its window write lands on the timeout edge.
        repeat (93) @(negedge clock);
        send("tie", 21'd12, 8'd10, 1'b1);
        repeat (97) @(negedge clock);
        chk("pre_stale", stale, 0);
        chk("pre_stale_near", near, 1);
        @(negedge clock);
        chk("stale_set", stale, 1);
        chk("stale_near", near, 0);
        chk("stale_avg_hold", avg_out, 10);
        repeat (5) @(negedge clock);
        chk("stale_hold", stale, 1);
        send("reprime50", 21'd50, 8'd50, 1'b0);

        // Reset while echo is high in RUN; the next fall must prime.
        echo        = 1'b1;
        distance_in = 21'd60;
        resetn      = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        chk("midrst_avg", avg_out, 0);
        chk("midrst_valid", avg_valid, 0);
        chk("midrst_near", near, 0);
        chk("midrst_stale", stale, 0);
        send("midrst_prime", 21'd60, 8'd60, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
